// File: rtl/arbiter_pkg.sv
// Shared types and select-line encodings for the I/D-cache memory arbiter.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_I  = 2'd1,
        SERVE_D  = 2'd2,
        PREFETCH = 2'd3
    } arb_state_t;

    // Which cache was granted most recently; used to break ties.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [1:0] ADDR_I    = 2'b00;
    localparam logic [1:0] ADDR_D    = 2'b01;
    localparam logic [1:0] ADDR_PF   = 2'b10;
    localparam logic [1:0] ADDR_NONE = 2'b11;

    localparam logic [1:0] RW_I      = 2'b00;
    localparam logic [1:0] RW_D      = 2'b01;
    localparam logic [1:0] RW_PF     = 2'b10;
    localparam logic [1:0] RW_IDLE   = 2'b11;

    localparam logic [1:0] RESP_I    = 2'b00;
    localparam logic [1:0] RESP_D    = 2'b01;
    localparam logic [1:0] RESP_PF   = 2'b10;
    localparam logic [1:0] RESP_NONE = 2'b11;

    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/arbiter_control.sv
// Sequencing FSM for the shared I/D-cache physical-memory arbiter.
// Round-robin on simultaneous requests, optional next-line I prefetch.
module arbiter_control
    import arbiter_pkg::*;
#(
    parameter bit PREFETCH_EN = 1'b1,
    parameter int LINE_BYTES  = (1 << LINE_OFFSET_W),
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_read_i,
    input  logic             icache_write_i,
    input  logic [31:0]      icache_address_i,
    input  logic             dcache_read_i,
    input  logic             dcache_write_i,
    input  logic             resp_o,
    output logic [1:0]       addr_sel,
    output logic [1:0]       rw_sel,
    output logic             mem_wdata_sel,
    output logic             mem_rdata_sel,
    output logic [1:0]       resp_sel,
    output logic [31:0]      prefetch_addr,
    output logic [CNT_W-1:0] prefetch_cnt
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int LW    = 32 - OFF_W;

    arb_state_t       state_q, state_d;
    grant_t           grant_q, grant_d;
    logic [31:0]      pfa_q, pfa_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          req_i, req_d;
    logic [LW-1:0] line;
    logic [LW-1:0] line_next;
    logic          wrap;
    logic          unused_addr_bits;

    assign req_i     = icache_read_i | icache_write_i;
    assign req_d     = dcache_read_i | dcache_write_i;
    assign line      = icache_address_i[31:OFF_W];
    assign line_next = line + LW'(1);
    // The line after the top of the address space would wrap to 0; never prefetch it.
    assign wrap      = &line;
    // Byte offset within the line is irrelevant to the prefetch target.
    assign unused_addr_bits = ^icache_address_i[OFF_W-1:0];

    assign prefetch_addr = pfa_q;
    assign prefetch_cnt  = cnt_q;

    // State, grant history, prefetch address and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= GRANT_I;
            pfa_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pfa_q   <= pfa_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, hold each transfer until resp_o.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pfa_d   = pfa_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (req_i && (!req_d || grant_q == GRANT_D)) begin
                    state_d = SERVE_I;
                    grant_d = GRANT_I;
                end else if (req_d) begin
                    state_d = SERVE_D;
                    grant_d = GRANT_D;
                end
            end
            SERVE_I: begin
                if (resp_o) begin
                    state_d = IDLE;
                    if (!wrap) begin
                        pfa_d = {line_next, {OFF_W{1'b0}}};
                    end
                    // A waiting D-cache request takes priority over speculation.
                    if (PREFETCH_EN && !req_d && !wrap) begin
                        state_d = PREFETCH;
                    end
                end
            end
            SERVE_D: begin
                if (resp_o) begin
                    state_d = IDLE;
                end
            end
            PREFETCH: begin
                if (resp_o) begin
                    state_d = IDLE;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode of the datapath select lines from the current state.
    always_comb begin
        addr_sel      = ADDR_NONE;
        rw_sel        = RW_IDLE;
        resp_sel      = RESP_NONE;
        mem_wdata_sel = 1'b0;
        mem_rdata_sel = 1'b0;
        case (state_q)
            SERVE_I: begin
                addr_sel = ADDR_I;
                rw_sel   = RW_I;
                resp_sel = RESP_I;
            end
            SERVE_D: begin
                addr_sel      = ADDR_D;
                rw_sel        = RW_D;
                resp_sel      = RESP_D;
                mem_wdata_sel = 1'b1;
                mem_rdata_sel = 1'b1;
            end
            PREFETCH: begin
                addr_sel = ADDR_PF;
                rw_sel   = RW_PF;
                resp_sel = RESP_PF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arbiter_control.sv
// Scenario bench for arbiter_control: per-cycle expectations are queued as
// stimulus is applied and popped once the DUT has clocked.
module tb_arbiter_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_read_i = 1'b0;
    logic        icache_write_i = 1'b0;
    logic [31:0] icache_address_i = '0;
    logic        dcache_read_i = 1'b0;
    logic        dcache_write_i = 1'b0;
    logic        resp_o = 1'b0;
    logic [1:0]  addr_sel;
    logic [1:0]  rw_sel;
    logic        mem_wdata_sel;
    logic        mem_rdata_sel;
    logic [1:0]  resp_sel;
    logic [31:0] prefetch_addr;
    logic [15:0] prefetch_cnt;

    // {addr_sel, rw_sel, resp_sel, wdata_sel, rdata_sel}
    localparam logic [7:0] E_N = 8'b11_11_11_0_0;
    localparam logic [7:0] E_I = 8'b00_00_00_0_0;
    localparam logic [7:0] E_D = 8'b01_01_01_1_1;
    localparam logic [7:0] E_P = 8'b10_10_10_0_0;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {encoding, prefetch_addr, prefetch_cnt}
    logic [55:0] exp_q [$];
    logic [7:0]  obs;
    assign obs = {addr_sel, rw_sel, resp_sel, mem_wdata_sel, mem_rdata_sel};

    arbiter_control #(
        .PREFETCH_EN(1'b1),
        .LINE_BYTES (32),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icache_read_i   (icache_read_i),
        .icache_write_i  (icache_write_i),
        .icache_address_i(icache_address_i),
        .dcache_read_i   (dcache_read_i),
        .dcache_write_i  (dcache_write_i),
        .resp_o          (resp_o),
        .addr_sel        (addr_sel),
        .rw_sel          (rw_sel),
        .mem_wdata_sel   (mem_wdata_sel),
        .mem_rdata_sel   (mem_rdata_sel),
        .resp_sel        (resp_sel),
        .prefetch_addr   (prefetch_addr),
        .prefetch_cnt    (prefetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [36:0] s);
        {icache_read_i, icache_write_i, dcache_read_i, dcache_write_i, resp_o,
         icache_address_i} = s;
    endtask

    task automatic apply_reset();
        drive('0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [55:0] e;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive({5'($urandom), 32'($urandom)});
            exp_q.push_back({E_N, 32'h0, 16'd0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
        drive({5'b10000, 32'h40});
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (obs !== E_N) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, E_N);
        end
        exp_q.push_back({E_I, 32'h0, 16'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h/%h/%0d want %h/%h/%0d",
                     obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
        end
    endtask

    task automatic test_prefetch();
        logic [36:0] st [7];
        logic [55:0] ex [7];
        logic [55:0] e;
        st = '{{5'b10000, 32'h1044}, {5'b10000, 32'h1044}, {5'b10000, 32'h1044},
               {5'b10001, 32'h1044}, {5'b00000, 32'h1044}, {5'b00001, 32'h1044},
               {5'b00000, 32'h1044}};
        ex = '{{E_I, 32'h0, 16'd0}, {E_I, 32'h0, 16'd0}, {E_I, 32'h0, 16'd0},
               {E_P, 32'h1060, 16'd0}, {E_P, 32'h1060, 16'd0},
               {E_N, 32'h1060, 16'd1}, {E_N, 32'h1060, 16'd1}};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL prefetch row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [36:0] st [6];
        logic [55:0] ex [6];
        logic [55:0] e;
        st = '{{5'b10010, 32'h0}, {5'b10011, 32'h0}, {5'b01010, 32'h0},
               {5'b01011, 32'h0}, {5'b10010, 32'h0}, {5'b00001, 32'h0}};
        ex = '{{E_D, 32'h0, 16'd0}, {E_N, 32'h0, 16'd0}, {E_I, 32'h0, 16'd0},
               {E_N, 32'h20, 16'd0}, {E_D, 32'h20, 16'd0}, {E_N, 32'h20, 16'd0}};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL round_robin row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
    endtask

    task automatic test_dreq_blocks_pf();
        logic [36:0] st [6];
        logic [55:0] ex [6];
        logic [55:0] e;
        st = '{{5'b10000, 32'h2000}, {5'b10100, 32'h2000}, {5'b10101, 32'h2000},
               {5'b00100, 32'h2000}, {5'b00101, 32'h2000}, {5'b00000, 32'h2000}};
        ex = '{{E_I, 32'h0, 16'd0}, {E_I, 32'h0, 16'd0}, {E_N, 32'h2020, 16'd0},
               {E_D, 32'h2020, 16'd0}, {E_N, 32'h2020, 16'd0}, {E_N, 32'h2020, 16'd0}};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL dreq_blocks_pf row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [36:0] st [6];
        logic [55:0] ex [6];
        logic [55:0] e;
        st = '{{5'b10000, 32'h500}, {5'b10001, 32'h500}, {5'b00001, 32'h500},
               {5'b10000, 32'hFFFF_FFE4}, {5'b10001, 32'hFFFF_FFE4},
               {5'b00000, 32'hFFFF_FFE4}};
        ex = '{{E_I, 32'h0, 16'd0}, {E_P, 32'h520, 16'd0}, {E_N, 32'h520, 16'd1},
               {E_I, 32'h520, 16'd1}, {E_N, 32'h520, 16'd1}, {E_N, 32'h520, 16'd1}};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL wrap row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_prefetch();
        logic [36:0] st [6];
        logic [55:0] ex [6];
        logic [36:0] st2 [3];
        logic [55:0] ex2 [3];
        logic [55:0] e;
        st = '{{5'b10000, 32'h40}, {5'b10001, 32'h40}, {5'b00001, 32'h40},
               {5'b10000, 32'h80}, {5'b10001, 32'h80}, {5'b00000, 32'h80}};
        ex = '{{E_I, 32'h0, 16'd0}, {E_P, 32'h60, 16'd0}, {E_N, 32'h60, 16'd1},
               {E_I, 32'h60, 16'd1}, {E_P, 32'hA0, 16'd1}, {E_P, 32'hA0, 16'd1}};
        st2 = '{{5'b10000, 32'h100}, {5'b10001, 32'h100}, {5'b00001, 32'h100}};
        ex2 = '{{E_I, 32'h0, 16'd0}, {E_P, 32'h120, 16'd0}, {E_N, 32'h120, 16'd1}};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(st[k]);
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL mid_pf_pre row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
        // Pull reset between clock edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        exp_q.push_back({E_N, 32'h0, 16'd0});
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
            n_fail++;
            $display("FAIL mid_pf_async: got %h/%h/%0d want %h/%h/%0d",
                     obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(st2[k]);
            exp_q.push_back(ex2[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({obs, prefetch_addr, prefetch_cnt} !== e) begin
                n_fail++;
                $display("FAIL mid_pf_post row %0d: got %h/%h/%0d want %h/%h/%0d", k,
                         obs, prefetch_addr, prefetch_cnt, e[55:48], e[47:16], e[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_round_robin();
        test_dreq_blocks_pf();
        test_wrap();
        test_reset_mid_prefetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
